mcu_spi_cmd_bridge: RTL and testbench

//  Next-gen bus-to-MCU command bridge, generalising the fixed-length RTC command engine.
//  - Host sets a command and a payload length, then streams bytes through TX/RX FIFOs.
//  - Engine frames one SPI transaction to the MCU: CS, command byte, ack, N data bytes, end ack.
//  - Adds FIFO buffering, programmable length, ack timeout and an IRQ.

---
 rtl/mcu_spi_cmd_bridge.sv | 209 ++++++++++++++++++++
 tb/tb_mcu_spi_cmd_bridge.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_spi_cmd_bridge.sv
// mcu_spi_cmd_bridge: bus-programmed SPI command engine framing CS/cmd/ack/data/end-ack
// transactions to an MCU, with TX/RX byte FIFOs, programmable length, ack timeout and IRQ.
module mcu_spi_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        empty,
  output logic        full,
  output logic [AW:0] level
);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] lvl_q;
  logic do_push, do_pop;
  assign level = lvl_q;
  assign empty = lvl_q == '0;
  assign full = lvl_q == (AW+1)'(DEPTH);
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem_q[rp_q];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      lvl_q <= '0;
    end else if (flush) begin
      wp_q <= '0;
      rp_q <= '0;
      lvl_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(do_push);
      rp_q <= rp_q + AW'(do_pop);
      lvl_q <= lvl_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q] <= din;
endmodule

module mcu_spi_cmd_bridge #(
  parameter int FIFO_DEPTH  = 8,
  parameter int LEN_WIDTH   = 8,
  parameter int CMD_BITS    = 4,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic       SClk,
  input  logic       Reset,
  input  logic       BusWrite,
  input  logic       BusRead,
  input  logic [1:0] BusAddr,
  input  logic [7:0] WriteData,
  output logic [7:0] ReadData,
  input  logic       SPIDi,
  output logic       SPIDo,
  output logic       nMCUSel,
  input  logic       MCUReadyFallingEdge,
  output logic       SPIClkRunning,
  output logic       SPIClkStretch,
  output logic       Irq
);
  localparam int LW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT + 2);
  typedef enum logic [2:0] {IDLE, LOWER_CS, SEND_CMD, WAIT_ACK, LOAD, SEND_DATA, WAIT_END, RAISE_CS} state_t;
  state_t state_q, state_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] bit_q, bit_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d, len_q, len_d;
  logic [CMD_BITS-1:0] cmd_q, cmd_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic ack_q, ack_d, done_q, done_d, tmo_q, tmo_d, ovf_q, ovf_d, irqen_q, irqen_d, nsel_q, nsel_d;
  logic wr_data, wr_ctrl, wr_len, rd_pop, busy, start, flush, w1c, is_rd, tmo_hit;
  logic tx_pop, rx_push, done_set, tmo_set;
  logic [7:0] tx_dout, rx_dout, status;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic [LW:0] tx_lvl, rx_lvl;

  function automatic logic [3:0] sat4(input logic [LW:0] v);
    return (32'(v) > 15) ? 4'hF : 4'(v);
  endfunction

  assign wr_data = BusWrite && BusAddr == 2'd0;
  assign wr_ctrl = BusWrite && BusAddr == 2'd1;
  assign wr_len = BusWrite && BusAddr == 2'd2;
  assign rd_pop = BusRead && BusAddr == 2'd0;
  assign busy = state_q != IDLE;
  assign start = wr_ctrl && !busy && WriteData[4];
  assign flush = wr_ctrl && !busy && WriteData[5];
  assign w1c = wr_ctrl && WriteData[7];
  assign is_rd = cmd_q[0];
  assign tmo_hit = (ACK_TIMEOUT > 0) && (32'(tcnt_q) >= ACK_TIMEOUT - 1);

  mcu_spi_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .clk(SClk), .rst(Reset), .flush(flush), .push(wr_data), .pop(tx_pop), .din(WriteData),
    .dout(tx_dout), .empty(tx_empty), .full(tx_full), .level(tx_lvl)
  );
  mcu_spi_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .clk(SClk), .rst(Reset), .flush(flush), .push(rx_push), .pop(rd_pop), .din({sh_q[6:0], SPIDi}),
    .dout(rx_dout), .empty(rx_empty), .full(rx_full), .level(rx_lvl)
  );

  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    bit_d = bit_q;
    rem_d = rem_q;
    ack_d = ack_q | MCUReadyFallingEdge;
    tx_pop = 1'b0;
    rx_push = 1'b0;
    done_set = 1'b0;
    tmo_set = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOWER_CS;
        rem_d = len_q;
      end
      LOWER_CS: begin
        sh_d = {{(8-CMD_BITS){1'b1}}, cmd_q};
        ack_d = 1'b0;
        state_d = SEND_CMD;
      end
      SEND_CMD, SEND_DATA: begin
        sh_d = {sh_q[6:0], SPIDi};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          if (state_q == SEND_CMD) state_d = WAIT_ACK;
          else begin
            rx_push = is_rd;
            rem_d = rem_q - LEN_WIDTH'(1);
            state_d = (rem_q > LEN_WIDTH'(1)) ? LOAD : WAIT_END;
          end
        end
      end
      WAIT_ACK, WAIT_END: if (ack_q) begin
        ack_d = MCUReadyFallingEdge;
        state_d = (state_q == WAIT_END) ? RAISE_CS : (rem_q != '0) ? LOAD : WAIT_END;
      end else if (tmo_hit) begin
        tmo_set = 1'b1;
        state_d = RAISE_CS;
      end
      LOAD: if (is_rd ? !rx_full : !tx_empty) begin
        tx_pop = !is_rd;
        sh_d = is_rd ? 8'hFF : tx_dout;
        state_d = SEND_DATA;
      end
      RAISE_CS: begin
        done_set = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // any state change restarts the count, so each wait state starts from zero
    tcnt_d = (state_d == state_q) ? tcnt_q + TW'(1) : '0;
  end

  assign len_d = (wr_len && !busy) ? WriteData[LEN_WIDTH-1:0] : len_q;
  assign cmd_d = (wr_ctrl && !busy) ? WriteData[CMD_BITS-1:0] : cmd_q;
  assign irqen_d = wr_ctrl ? WriteData[6] : irqen_q;
  assign done_d = done_set | (done_q & ~start & ~w1c);
  assign tmo_d = tmo_set | (tmo_q & ~start & ~w1c);
  assign ovf_d = (wr_data & tx_full) | (ovf_q & ~w1c);
  assign nsel_d = (state_q == LOWER_CS) ? 1'b0 : (state_q == RAISE_CS) ? 1'b1 : nsel_q;

  always_ff @(posedge SClk or posedge Reset)
    if (Reset) begin
      state_q <= IDLE;
      sh_q <= 8'hFF;
      bit_q <= '0;
      rem_q <= '0;
      len_q <= '0;
      cmd_q <= '0;
      tcnt_q <= '0;
      ack_q <= 1'b0;
      done_q <= 1'b0;
      tmo_q <= 1'b0;
      ovf_q <= 1'b0;
      irqen_q <= 1'b0;
      nsel_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      bit_q <= bit_d;
      rem_q <= rem_d;
      len_q <= len_d;
      cmd_q <= cmd_d;
      tcnt_q <= tcnt_d;
      ack_q <= ack_d;
      done_q <= done_d;
      tmo_q <= tmo_d;
      ovf_q <= ovf_d;
      irqen_q <= irqen_d;
      nsel_q <= nsel_d;
    end

  assign status = {done_q, tmo_q, busy, ovf_q, tx_full, tx_empty, rx_full, rx_empty};
  assign ReadData = (BusAddr == 2'd0) ? (rx_empty ? 8'hFF : rx_dout) :
                    (BusAddr == 2'd1) ? status :
                    (BusAddr == 2'd2) ? 8'(len_q) : {sat4(tx_lvl), sat4(rx_lvl)};
  assign SPIDo = sh_q[7];
  assign nMCUSel = nsel_q;
  assign SPIClkRunning = !(state_q inside {IDLE, LOWER_CS, RAISE_CS});
  assign SPIClkStretch = state_q inside {WAIT_ACK, LOAD, WAIT_END};
  assign Irq = irqen_q & done_q;
endmodule

// File: tb/tb_mcu_spi_cmd_bridge.sv
// tb_mcu_spi_cmd_bridge: register vector table, directed SPI framing corner cases and
// random transactions checked against a byte-level model of the expected MOSI/RX streams.
module tb_mcu_spi_cmd_bridge;
  logic clk = 1'b0, rst = 1'b1;
  logic bw = 1'b0, br = 1'b0;
  logic [1:0] ba = 2'd0;
  logic [7:0] wd = 8'h00, rd;
  logic miso = 1'b0, mosi, ncs, ack = 1'b0, run, str, irq;

  mcu_spi_cmd_bridge #(.ACK_TIMEOUT(16)) dut (
    .SClk(clk), .Reset(rst), .BusWrite(bw), .BusRead(br), .BusAddr(ba), .WriteData(wd),
    .ReadData(rd), .SPIDi(miso), .SPIDo(mosi), .nMCUSel(ncs), .MCUReadyFallingEdge(ack),
    .SPIClkRunning(run), .SPIClkStretch(str), .Irq(irq)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;
  int xact_id = 0, seen_id = 0, exp_n = 0;
  logic auto_ack = 1'b1;
  logic [7:0] miso_a [0:31];
  int bitcnt = 0, bytecnt = 0, shifts = 0, owed = 0, gap = 0;
  logic cs_bad = 1'b0;
  logic [7:0] acc = 8'h00;
  logic [7:0] mosi_q [$];

  // MCU side: records MOSI bytes on shift cycles, drives MISO, pulses cmd and end acks
  always @(negedge clk) begin
    ack = 1'b0;
    if (xact_id != seen_id) begin
      seen_id = xact_id;
      bitcnt = 0;
      bytecnt = 0;
      shifts = 0;
      owed = 0;
      gap = 0;
      cs_bad = 1'b0;
      mosi_q.delete();
    end
    if (run && !str) begin
      miso = miso_a[bytecnt > 31 ? 31 : bytecnt][7-bitcnt];
      if (ncs) cs_bad = 1'b1;
      acc = {acc[6:0], mosi};
      shifts++;
      if (bitcnt == 7) begin
        mosi_q.push_back(acc);
        bitcnt = 0;
        bytecnt++;
        if (auto_ack) owed += int'(bytecnt == 1) + int'(bytecnt == exp_n + 1);
      end else bitcnt++;
    end
    if (gap > 0) gap--;
    else if (owed > 0) begin
      ack = 1'b1;
      owed--;
      gap = 3;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    ba = a;
    wd = d;
    bw = 1'b1;
    tick(1);
    bw = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, input logic pop, output logic [7:0] d);
    ba = a;
    #1 d = rd;
    br = pop;
    tick(1);
    br = 1'b0;
  endtask

  task automatic begin_xact(input int n);
    exp_n = n;
    xact_id++;
  endtask

  task automatic wait_idle(input string nm, input int maxc);
    int n = 0;
    ba = 2'd1;
    #1;
    while (rd[5] && n < maxc) begin
      tick(1);
      n++;
    end
    chk({nm, " idle"}, {31'd0, rd[5]}, 0);
  endtask

  task automatic pop_expect(input string nm, input logic [7:0] exp);
    int n = 0;
    logic [7:0] v;
    ba = 2'd1;
    #1;
    while (rd[0] && n < 50) begin
      tick(1);
      n++;
    end
    bus_rd(2'd0, 1'b1, v);
    chk(nm, v, exp);
  endtask

  typedef struct {
    logic wr;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;
  vec_t vt [17];

  logic [7:0] v;
  logic [7:0] dat [6];
  logic [7:0] exp_q [$];
  int n, m;
  logic r;
  logic [3:0] c;

  initial begin
    #100000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) miso_a[i] = 8'h00;
    vt[0]  = '{1'b0, 2'd1, 8'h00, 8'h05};
    vt[1]  = '{1'b0, 2'd0, 8'h00, 8'hFF};
    vt[2]  = '{1'b0, 2'd2, 8'h00, 8'h00};
    vt[3]  = '{1'b0, 2'd3, 8'h00, 8'h00};
    vt[4]  = '{1'b1, 2'd2, 8'h37, 8'h00};
    vt[5]  = '{1'b0, 2'd2, 8'h00, 8'h37};
    vt[6]  = '{1'b1, 2'd0, 8'h11, 8'h00};
    vt[7]  = '{1'b1, 2'd0, 8'h22, 8'h00};
    vt[8]  = '{1'b0, 2'd3, 8'h00, 8'h20};
    vt[9]  = '{1'b0, 2'd1, 8'h00, 8'h01};
    vt[10] = '{1'b1, 2'd1, 8'h20, 8'h00};
    vt[11] = '{1'b0, 2'd3, 8'h00, 8'h00};
    vt[12] = '{1'b0, 2'd1, 8'h00, 8'h05};
    vt[13] = '{1'b1, 2'd1, 8'h40, 8'h00};
    vt[14] = '{1'b0, 2'd1, 8'h00, 8'h05};
    vt[15] = '{1'b1, 2'd1, 8'h80, 8'h00};
    vt[16] = '{1'b0, 2'd2, 8'h00, 8'h37};

    tick(3);
    chk("rst ncs", {31'd0, ncs}, 1);
    chk("rst mosi", {31'd0, mosi}, 1);
    chk("rst run", {31'd0, run}, 0);
    chk("rst stretch", {31'd0, str}, 0);
    rst = 1'b0;
    tick(2);
    chk("rst irq", {31'd0, irq}, 0);

    for (int i = 0; i < 17; i++)
      if (vt[i].wr) bus_wr(vt[i].a, vt[i].d);
      else begin
        bus_rd(vt[i].a, 1'b1, v);
        chk($sformatf("vec%0d", i), v, vt[i].exp);
      end

    // write cmd 2, two payload bytes, IRQ enabled
    bus_wr(2'd2, 8'd2);
    bus_wr(2'd0, 8'h11);
    bus_wr(2'd0, 8'h22);
    begin_xact(2);
    bus_wr(2'd1, 8'h52);
    wait_idle("A", 200);
    chk("A nbytes", mosi_q.size(), 3);
    chk("A mosi0", mosi_q[0], 8'hF2);
    chk("A mosi1", mosi_q[1], 8'h11);
    chk("A mosi2", mosi_q[2], 8'h22);
    chk("A cs low", {31'd0, cs_bad}, 0);
    chk("A ncs end", {31'd0, ncs}, 1);
    chk("A irq", {31'd0, irq}, 1);
    bus_rd(2'd1, 1'b0, v);
    chk("A status", v, 8'h85);
    bus_wr(2'd1, 8'hC0);
    chk("A irq clr", {31'd0, irq}, 0);

    // read cmd 3, three bytes, IRQ disabled
    miso_a[1] = 8'hA5;
    miso_a[2] = 8'h5A;
    miso_a[3] = 8'hC3;
    bus_wr(2'd2, 8'd3);
    begin_xact(3);
    bus_wr(2'd1, 8'h13);
    wait_idle("B", 200);
    chk("B irq off", {31'd0, irq}, 0);
    chk("B mosi0", mosi_q[0], 8'hF3);
    chk("B mosi1", mosi_q[1], 8'hFF);
    pop_expect("B rx0", 8'hA5);
    pop_expect("B rx1", 8'h5A);
    pop_expect("B rx2", 8'hC3);
    bus_rd(2'd0, 1'b1, v);
    chk("B rx empty data", v, 8'hFF);
    bus_rd(2'd1, 1'b0, v);
    chk("B rx empty flag", {31'd0, v[0]}, 1);
    bus_wr(2'd1, 8'h80);

    // write with empty TX: stall in LOAD until late pushes
    bus_wr(2'd2, 8'd3);
    begin_xact(3);
    bus_wr(2'd1, 8'h12);
    tick(25);
    chk("C stretch", {31'd0, str}, 1);
    chk("C running", {31'd0, run}, 1);
    chk("C shifts stall", shifts, 8);
    bus_wr(2'd0, 8'h3C);
    bus_wr(2'd0, 8'hC3);
    bus_wr(2'd0, 8'h5A);
    wait_idle("C", 200);
    chk("C shifts", shifts, 32);
    chk("C mosi1", mosi_q[1], 8'h3C);
    chk("C mosi2", mosi_q[2], 8'hC3);
    chk("C mosi3", mosi_q[3], 8'h5A);
    bus_wr(2'd1, 8'h80);

    // read FIFO_DEPTH+2 with no pops: RX full backpressure
    for (int i = 1; i <= 10; i++) miso_a[i] = 8'($urandom);
    bus_wr(2'd2, 8'd10);
    begin_xact(10);
    bus_wr(2'd1, 8'h13);
    tick(120);
    chk("D bytes full", bytecnt, 9);
    chk("D stretch", {31'd0, str}, 1);
    bus_rd(2'd1, 1'b0, v);
    chk("D status", v, 8'h26);
    bus_rd(2'd3, 1'b0, v);
    chk("D levels", v, 8'h08);
    pop_expect("D rx1", miso_a[1]);
    tick(30);
    chk("D one more", bytecnt, 10);
    chk("D stall again", {31'd0, str}, 1);
    for (int i = 2; i <= 10; i++) pop_expect($sformatf("D rx%0d", i), miso_a[i]);
    wait_idle("D", 200);
    chk("D total", mosi_q.size(), 11);
    bus_wr(2'd1, 8'h80);

    // ack timeout
    auto_ack = 1'b0;
    bus_wr(2'd2, 8'd0);
    begin_xact(0);
    bus_wr(2'd1, 8'h12);
    n = 0;
    while (bytecnt < 1 && n < 40) begin
      tick(1);
      n++;
    end
    m = 0;
    while (!ncs && m < 40) begin
      tick(1);
      m++;
    end
    chk("E tmo latency", {31'd0, m >= 16 && m <= 18}, 1);
    bus_rd(2'd1, 1'b0, v);
    chk("E status", v, 8'hC5);
    bus_wr(2'd1, 8'h80);
    bus_rd(2'd1, 1'b0, v);
    chk("E w1c", v, 8'h05);
    auto_ack = 1'b1;

    // random transactions against byte-stream model
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(0, 5);
      r = 1'($urandom_range(0, 1));
      c = {3'($urandom_range(0, 7)), r};
      for (int i = 0; i < 6; i++) dat[i] = 8'($urandom);
      for (int i = 1; i <= 6; i++) miso_a[i] = 8'($urandom);
      exp_q.delete();
      exp_q.push_back({4'hF, c});
      for (int i = 0; i < n; i++) exp_q.push_back(r ? 8'hFF : dat[i]);
      bus_wr(2'd2, 8'(n));
      if (!r) for (int i = 0; i < n; i++) bus_wr(2'd0, dat[i]);
      begin_xact(n);
      bus_wr(2'd1, {4'h1, c});
      wait_idle("R", 300);
      chk("R nbytes", mosi_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) chk($sformatf("R%0d mosi%0d", t, i), mosi_q[i], exp_q[i]);
      if (r) for (int i = 0; i < n; i++) pop_expect($sformatf("R%0d rx%0d", t, i), miso_a[i+1]);
      bus_rd(2'd1, 1'b0, v);
      chk("R status", v, 8'h85);
      bus_wr(2'd1, 8'h80);
    end

    // async reset mid data byte, then TX overflow
    bus_wr(2'd2, 8'd2);
    bus_wr(2'd0, 8'hAA);
    bus_wr(2'd0, 8'hBB);
    begin_xact(2);
    bus_wr(2'd1, 8'h12);
    n = 0;
    while (!(bytecnt >= 1 && run && !str) && n < 60) begin
      tick(1);
      n++;
    end
    chk("F in data", {31'd0, run && !str && !ncs}, 1);
    ba = 2'd1;
    #2 rst = 1'b1;
    #1;
    chk("F ncs", {31'd0, ncs}, 1);
    chk("F run", {31'd0, run}, 0);
    chk("F stretch", {31'd0, str}, 0);
    chk("F mosi", {31'd0, mosi}, 1);
    chk("F status", rd, 8'h05);
    rst = 1'b0;
    tick(1);
    for (int i = 0; i < 9; i++) bus_wr(2'd0, 8'(i));
    bus_rd(2'd1, 1'b0, v);
    chk("F ovf status", v, 8'h19);
    bus_rd(2'd3, 1'b0, v);
    chk("F levels", v, 8'h80);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
